alu_serial_rx: RTL
==================

Name: alu_serial_rx

Overview:
Parametrised serial front-end for the ALU. It deserialises the `sin` packet stream into two operands and an opcode, and checks framing, data-packet count, CRC-4 and opcode legality. It presents either a result or an error code on a valid/ready interface to the ALU core. Operand width is generalised from a fixed 32 bits to OPERAND_BYTES bytes, and it adds error reporting and backpressure/overrun handling.

Parameters:
- OPERAND_BYTES, 4, bytes per operand (>=1). DATA_W = 8*OPERAND_BYTES is a localparam.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous active-low
- sin  in  1  serial input, idle high; sender drives on negedge, block samples on posedge
- ready_i  in  1  consumer accepts the presented record
- valid_o  out  1  record available
- a_o  out  DATA_W  operand A
- b_o  out  DATA_W  operand B
- op_o  out  3  opcode
- err_o  out  1  record is an error record
- err_code_o  out  3  one-hot {ERR_DATA, ERR_CRC, ERR_OP}
- overrun_o  out  1  one-cycle pulse: completed record dropped

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM in IDLE, bit counter, data counter, shift buffer and CRC all 0. Reset mid-frame discards the partial frame and any pending record.
- Packet format: 11 bits, MSB first: start(0), type(0=data, 1=cmd), payload[7:0], stop(1).
- Data packets fill a 2*DATA_W shift buffer. A is taken from the first OPERAND_BYTES bytes, MSB byte first; B from the next OPERAND_BYTES bytes.
- Cmd payload is {ignored bit, op[2:0], crc[3:0]}.
- FSM IDLE: sin=0 sampled -> RX with bit count 1. Otherwise stay.
- FSM RX: samples one bit per clk; the stop bit is sample 11.
  - Stop=1 on a data packet: data counter increments, saturating at 2*OPERAND_BYTES+1. -> IDLE.
  - Stop=1 on a cmd packet: evaluate the frame (see below), clear the data counter, -> IDLE.
  - Stop=0: framing error. Produce an ERR_DATA record, clear the data counter, -> WAIT_HIGH.
- FSM WAIT_HIGH: stay until sin=1 is sampled, then -> IDLE.
- Back-to-back packets are allowed: a start bit may be sampled on the cycle immediately after a stop bit.
- CRC: CRC-4, polynomial x^4+x+1, initial value 0, no reflection, no final XOR.
  - Input is {A, B, 1'b1, op}, MSB first, 2*DATA_W+4 bits.
  - Computed serially as payload bits arrive, one bit per clk, so no extra latency.
  - CRC resets to 0 at each cmd evaluation and on framing error.
- Cmd evaluation priority (exactly one error bit is set):
  - data count != 2*OPERAND_BYTES -> ERR_DATA.
  - else computed CRC != received crc -> ERR_CRC.
  - else op not in {000 AND, 001 OR, 100 ADD, 101 SUB} -> ERR_OP.
  - else success record: err_o=0, err_code_o=0, a_o/b_o/op_o loaded.
- Error records: a_o, b_o and op_o are held at their previous values and must be ignored by the consumer.
- Latency: valid_o is registered high at the posedge that samples the cmd stop bit (or the bad stop bit).
- Handshake:
  - The record stays stable while valid_o=1 and ready_i=0.
  - Transfer occurs on a posedge with valid_o and ready_i both high. valid_o drops the next cycle unless a new record completes on that same edge; in that case the new record is loaded and valid_o stays 1.
  - ready_i high while valid_o=0 has no effect.
- Overrun: a record completing while valid_o=1 and ready_i=0 is dropped. The held record is unchanged and overrun_o=1 for that one cycle.
- Reception never stalls; sin is not flow-controlled.

Test Plan:
- A=0, B=0, eight data packets of payload 0x00, then cmd payload 0x0B (AND, crc 1011), ready_i=1 -> valid_o=1 for 1 cycle at the cmd stop-bit edge; a_o=0, b_o=0, op_o=000, err_o=0.
- Same frame with cmd payload 0x0A -> err_o=1, err_code_o=3'b010 (ERR_CRC).
- Seven data packets, then cmd 0x0B -> err_code_o=3'b100 (ERR_DATA). Repeat with nine data packets -> 3'b100.
- A=B=0, cmd payload 0x2D (op 010, crc 1101) -> err_code_o=3'b001 (ERR_OP). Data packet with stop bit 0 -> ERR_DATA immediately; then a correct frame is received normally.
- ready_i=0: send two valid frames back-to-back -> the first record is held stable, overrun_o pulses once at the second cmd stop bit. Raise ready_i -> the first record transfers and valid_o drops.
- Assert rst_n=0 mid-way through packet 5, then release -> all outputs 0. A following complete valid frame is accepted with err_o=0. Rerun the suite with OPERAND_BYTES=1 and 8, using CRCs from the model.

Source files
------------

// File: rtl/alu_serial_rx.sv
// alu_serial_rx: deserialises sin packets into ALU operands/opcode, checks framing,
// data count, CRC-4 and opcode, and presents a result or error record on valid/ready.
module alu_serial_rx #(
    parameter int OPERAND_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sin,
    input  logic                       ready_i,
    output logic                       valid_o,
    output logic [8*OPERAND_BYTES-1:0] a_o,
    output logic [8*OPERAND_BYTES-1:0] b_o,
    output logic [2:0]                 op_o,
    output logic                       err_o,
    output logic [2:0]                 err_code_o,
    output logic                       overrun_o
);
    localparam int DATA_W = 8*OPERAND_BYTES;
    localparam int NB = 2*OPERAND_BYTES;
    localparam int CW = $clog2(NB + 2);

    typedef enum logic [1:0] {IDLE, RX, WAIT_HIGH} state_t;

    state_t              state_q, state_d;
    logic [3:0]          bitcnt_q;
    logic                is_cmd_q;
    logic [6:0]          pay_q;
    logic [2*DATA_W-1:0] shreg_q;
    logic [CW-1:0]       dcnt_q;
    logic [3:0]          crc_q, crc_nx;
    logic                rx, stop_smp, pay_smp, crc_en, crc_fb, rec_done, hold;
    logic [2:0]          rec_code;

    // bitcnt_q counts samples already taken in this packet; sample 11 is the stop bit
    assign rx       = state_q == RX;
    assign stop_smp = rx && bitcnt_q == 4'd10;
    assign pay_smp  = rx && bitcnt_q >= 4'd2 && bitcnt_q <= 4'd9;
    // CRC covers data payloads, the cmd type bit (always 1) and the three op bits
    assign crc_en   = rx && ((bitcnt_q == 4'd1 && sin) || (!is_cmd_q && pay_smp) ||
                             (is_cmd_q && bitcnt_q >= 4'd3 && bitcnt_q <= 4'd5));
    assign crc_fb   = crc_q[3] ^ sin;
    assign crc_nx   = {crc_q[2:0], 1'b0} ^ {2'b00, crc_fb, crc_fb};
    assign rec_done = stop_smp && (!sin || is_cmd_q);
    assign hold     = valid_o && !ready_i;

    always_comb begin
        state_d = (state_q == IDLE) ? (sin ? IDLE : RX) :
                  (state_q == RX)   ? (stop_smp ? (sin ? IDLE : WAIT_HIGH) : RX) :
                                      (sin ? IDLE : WAIT_HIGH);
        rec_code = 3'b000;
        if (!sin || dcnt_q != CW'(NB))
            rec_code = 3'b100;
        else if (crc_q != pay_q[3:0])
            rec_code = 3'b010;
        else if (pay_q[5])
            rec_code = 3'b001;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt_q <= '0;
            is_cmd_q <= 1'b0;
            pay_q    <= '0;
            shreg_q  <= '0;
            dcnt_q   <= '0;
            crc_q    <= '0;
        end else begin
            bitcnt_q <= rx ? (stop_smp ? 4'd0 : bitcnt_q + 4'd1) : {3'b000, state_q == IDLE && !sin};
            if (rx && bitcnt_q == 4'd1)
                is_cmd_q <= sin;
            if (pay_smp)
                pay_q <= {pay_q[5:0], sin};
            if (pay_smp && !is_cmd_q)
                shreg_q <= {shreg_q[2*DATA_W-2:0], sin};
            if (stop_smp)
                dcnt_q <= (sin && !is_cmd_q) ? (dcnt_q == CW'(NB + 1) ? dcnt_q : dcnt_q + 1'b1) : '0;
            if (stop_smp && (is_cmd_q || !sin))
                crc_q <= '0;
            else if (crc_en)
                crc_q <= crc_nx;
        end
    end

    // a record completing while the previous one is still held is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o    <= 1'b0;
            a_o        <= '0;
            b_o        <= '0;
            op_o       <= '0;
            err_o      <= 1'b0;
            err_code_o <= '0;
            overrun_o  <= 1'b0;
        end else begin
            overrun_o <= rec_done && hold;
            if (rec_done && !hold) begin
                valid_o    <= 1'b1;
                err_o      <= |rec_code;
                err_code_o <= rec_code;
                if (rec_code == 3'b000) begin
                    a_o  <= shreg_q[2*DATA_W-1:DATA_W];
                    b_o  <= shreg_q[DATA_W-1:0];
                    op_o <= pay_q[6:4];
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end
endmodule
